fft_frame_arbiter: RTL and testbench

Shares one `fft_core` between `NUM_REQ` independent sample sources at frame granularity. Whole `FRAME_LEN`-sample frames are granted round-robin and streamed into the core over its valid/ready handshake. Each frame's source index is remembered in a tag FIFO so that the matching output frame is steered back to the originating sink. The arbiter sits directly in front of and behind `fft_core`; the core's own ports are connected to the `core_*` ports here.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_tag_fifo.sv | 70 +++++++
 rtl/fft_frame_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared configuration and types for the FFT frame arbiter.
//   DATA_WIDTH  packed complex sample width carried by fft_core
//   FRAME_LEN   samples per frame (power of two)
//   NUM_REQ     number of requesters sharing the core
//   TAG_DEPTH   maximum frames in flight inside the core (power of two)
//   arb_state_t input-side FSM state
//   tag_t       requester index stored per in-flight frame
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int DATA_WIDTH = 50;
    localparam int FRAME_LEN  = 8;
    localparam int NUM_REQ    = 2;
    localparam int TAG_DEPTH  = 4;
    localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_t;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// ---------------------------------------------------------------------------
// fft_tag_fifo
// Synchronous FIFO holding the requester index of every frame that has been
// sent into the core and not yet fully returned.
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  tag to store
//   pop        discard the head entry (ignored when empty)
//   head       current head tag, combinational read
//   full/empty occupancy flags, derived from registered count only
// ---------------------------------------------------------------------------
module fft_tag_fifo #(
    parameter int WIDTH = fft_pkg::TAG_W,
    parameter int DEPTH = fft_pkg::TAG_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    import fft_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fft_frame_arbiter.sv
// ---------------------------------------------------------------------------
// fft_frame_arbiter
// Shares one fft_core between NUM_REQ sample sources at frame granularity.
// Whole frames are granted round-robin and streamed into the core; the
// source index of each frame is queued so the matching result frame is
// steered back to the originating sink.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | arbitration cycle; grant the next valid requester if a tag slot
//        | is free
// STREAM | pass the granted requester's frame to the core, FRAME_LEN beats
//
// Ports
//   clk_i, rst_i              clock / asynchronous active-low reset
//   s_signal_i, s_valid_i     requester samples, slice k = requester k
//   s_ready_o                 per-requester ready (only the granted one)
//   core_signal_o/valid_o     sample stream into fft_core
//   core_ready_i              fft_core input ready
//   core_signal_i/valid_i     result stream from fft_core
//   core_ready_o              result ready back to fft_core
//   m_signal_o, m_valid_o     result sample (shared) and one-hot sink valid
//   m_ready_i                 per-sink ready
//   busy_o                    frame being accepted or frames in flight
//   err_o                     sticky: core produced output with no tag queued
// ---------------------------------------------------------------------------
module fft_frame_arbiter #(
    parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
    parameter int FRAME_LEN  = fft_pkg::FRAME_LEN,
    parameter int NUM_REQ    = fft_pkg::NUM_REQ,
    parameter int TAG_DEPTH  = fft_pkg::TAG_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_signal_i,
    input  logic [NUM_REQ-1:0]            s_valid_i,
    output logic [NUM_REQ-1:0]            s_ready_o,
    output logic [DATA_WIDTH-1:0]         core_signal_o,
    output logic                          core_valid_o,
    input  logic                          core_ready_i,
    input  logic [DATA_WIDTH-1:0]         core_signal_i,
    input  logic                          core_valid_i,
    output logic                          core_ready_o,
    output logic [DATA_WIDTH-1:0]         m_signal_o,
    output logic [NUM_REQ-1:0]            m_valid_o,
    input  logic [NUM_REQ-1:0]            m_ready_i,
    output logic                          busy_o,
    output logic                          err_o
);
    import fft_pkg::*;

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [TW-1:0] grant_q;
    logic [TW-1:0] last_grant_q;
    logic [TW-1:0] winner;
    logic [TW-1:0] head;
    logic [TW-1:0] cand_idx;
    logic [CW-1:0] in_cnt_q;
    logic [CW-1:0] out_cnt_q;
    logic          found;
    logic          do_grant;
    logic          in_beat;
    logic          out_beat;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          err_q;
    int            cand;

    // Round-robin search starting one past the previous winner.
    always_comb begin
        winner   = last_grant_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = TW'(cand);
            if (!found && s_valid_i[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        do_grant      = 1'b0;
        in_beat       = 1'b0;
        s_ready_o     = '0;
        core_valid_o  = 1'b0;
        core_signal_o = s_signal_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        case (state_q)
            IDLE: begin
                // fifo_full comes from registered count: a pop in this same
                // cycle does not free a slot until the next one.
                if (found && !fifo_full) begin
                    do_grant = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                core_valid_o       = s_valid_i[grant_q];
                s_ready_o[grant_q] = core_ready_i;
                in_beat            = s_valid_i[grant_q] & core_ready_i;
                if (in_beat && (in_cnt_q == LAST_BEAT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output steering; with no tag queued the core is drained so a stray
    // result can never block it.
    always_comb begin
        m_valid_o    = '0;
        core_ready_o = 1'b1;
        out_beat     = 1'b0;
        pop          = 1'b0;
        if (!fifo_empty) begin
            m_valid_o[head] = core_valid_i;
            core_ready_o    = m_ready_i[head];
            out_beat        = core_valid_i & m_ready_i[head];
            pop             = out_beat && (out_cnt_q == LAST_BEAT);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= TW'(NUM_REQ - 1);
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                grant_q      <= winner;
                last_grant_q <= winner;
                in_cnt_q     <= '0;
            end else if (in_beat) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (pop) begin
                out_cnt_q <= '0;
            end else if (out_beat) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end
            if (core_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    fft_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (do_grant),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_signal_o = core_signal_i;
    assign busy_o     = (state_q == STREAM) | ~fifo_empty;
    assign err_o      = err_q;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
module tb_fft_frame_arbiter;

    localparam int DW = 50;
    localparam logic [DW-1:0] XORC = 50'h2AAAA;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [2*DW-1:0] s_signal_i;
    logic [1:0]      s_valid_i;
    logic [1:0]      s_ready_o;
    logic [DW-1:0]   core_signal_o;
    logic            core_valid_o;
    logic            core_ready_i;
    logic [DW-1:0]   core_signal_i;
    logic            core_valid_i;
    logic            core_ready_o;
    logic [DW-1:0]   m_signal_o;
    logic [1:0]      m_valid_o;
    logic [1:0]      m_ready_i;
    logic            busy_o;
    logic            err_o;

    int vectors = 0;
    int miscompares = 0;

    // Stand-in for fft_core: stores each accepted sample XOR a constant and
    // returns them in order. Shares the arbiter reset.
    logic [DW-1:0] cmem [64];
    logic [5:0]    cwr;
    logic [5:0]    crd;
    logic          core_out_en;
    logic          spur;

    assign core_valid_i  = spur | (core_out_en & (cwr != crd));
    assign core_signal_i = cmem[crd];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cwr <= '0;
            crd <= '0;
        end else begin
            if (core_valid_o && core_ready_i) cwr <= cwr + 1'b1;
            if (core_out_en && (cwr != crd) && core_ready_o) crd <= crd + 1'b1;
        end
    end

    always @(posedge clk_i) begin
        if (core_valid_o && core_ready_i) cmem[cwr] <= core_signal_o ^ XORC;
    end

    always #5 clk_i = ~clk_i;

    fft_frame_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_signal_i    (s_signal_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .core_signal_o (core_signal_o),
        .core_valid_o  (core_valid_o),
        .core_ready_i  (core_ready_i),
        .core_signal_i (core_signal_i),
        .core_valid_i  (core_valid_i),
        .core_ready_o  (core_ready_o),
        .m_signal_o    (m_signal_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        s_valid_i = 2'b00;
        spur      = 1'b0;
        rst_i     = 1'b0;
        #2;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset;
        s_signal_i   = '0;
        s_valid_i    = 2'b00;
        m_ready_i    = 2'b11;
        core_ready_i = 1'b1;
        core_out_en  = 1'b0;
        spur         = 1'b0;
        rst_i        = 1'b0;
        #2;
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_s_ready got %b want 00", s_ready_o); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_core_valid got %b want 0", core_valid_o); end
        vectors++; if (m_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_m_valid got %b want 00", m_valid_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_o); end
        vectors++; if (core_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_core_ready got %b want 1", core_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL reset_idle_ready got %b want 00", s_ready_o); end
    endtask

    task automatic test_single_frame;
        int bad = 0;
        int beats0 = 0;
        int other = 0;
        int dbad = 0;
        core_out_en = 1'b0;
        m_ready_i   = 2'b11;
        s_signal_i  = '0;
        s_signal_i[DW-1:0] = 50'h1;
        s_valid_i   = 2'b01;
        #1;
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL single_arb_cycle got %b want 00", s_ready_o); end
        tick();
        for (int b = 1; b <= 8; b++) begin
            s_signal_i[DW-1:0] = DW'(b);
            #1;
            if (!(core_valid_o === 1'b1 && s_ready_o === 2'b01 && core_signal_o === DW'(b))) bad++;
            tick();
        end
        s_valid_i = 2'b00;
        #1;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL single_in_beats got %0d bad beats want 0", bad); end
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL single_back_idle got %b want 00", s_ready_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_inflight got %b want 1", busy_o); end
        core_out_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (m_valid_o === 2'b01) begin
                if (m_signal_o !== (DW'(beats0 + 1) ^ XORC)) dbad++;
                beats0++;
            end else if (m_valid_o !== 2'b00) begin
                other++;
            end
            tick();
        end
        vectors++; if (beats0 !== 8) begin miscompares++; $display("FAIL single_out_beats got %0d want 8", beats0); end
        vectors++; if (other !== 0) begin miscompares++; $display("FAIL single_out_sink1 got %0d want 0", other); end
        vectors++; if (dbad !== 0) begin miscompares++; $display("FAIL single_out_data got %0d bad want 0", dbad); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL single_err got %b want 0", err_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_done got %b want 0", busy_o); end
    endtask

    task automatic test_contention;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0] rdy;
        logic [1:0] prev_rdy;
        logic [1:0] hs;
        int gorder[4];
        int osink[4];
        int nfr = 0;
        int beats_cur = 0;
        int flen_bad = 0;
        int gap = 0;
        int gap_bad = 0;
        int first_start = -1;
        int sent = 0;
        int onb = 0;
        int e0 = 0;
        int e1 = 0;
        int odbad = 0;
        int multi = 0;
        for (int i = 0; i < 4; i++) begin gorder[i] = -1; osink[i] = -1; end
        do_reset();
        core_out_en  = 1'b1;
        m_ready_i    = 2'b11;
        core_ready_i = 1'b1;
        d0 = 50'h1000;
        d1 = 50'h2000;
        s_signal_i = {d1, d0};
        s_valid_i  = 2'b11;
        prev_rdy   = 2'b00;
        for (int c = 0; c < 100 && !(sent == 32 && onb == 32); c++) begin
            #1;
            rdy = s_ready_o;
            if (rdy != 2'b00) begin
                if (prev_rdy == 2'b00) begin
                    if (nfr < 4) gorder[nfr] = rdy[1] ? 1 : 0;
                    if (nfr == 0) first_start = c;
                    else if (gap != 1) gap_bad++;
                    nfr++;
                    beats_cur = 0;
                end
                beats_cur++;
                gap = 0;
            end else begin
                if (prev_rdy != 2'b00 && beats_cur != 8) flen_bad++;
                gap++;
            end
            if (m_valid_o === 2'b01) begin
                if (m_signal_o !== ((50'h1000 + DW'(e0)) ^ XORC)) odbad++;
                if (onb % 8 == 0 && onb / 8 < 4) osink[onb / 8] = 0;
                e0++;
                onb++;
            end else if (m_valid_o === 2'b10) begin
                if (m_signal_o !== ((50'h2000 + DW'(e1)) ^ XORC)) odbad++;
                if (onb % 8 == 0 && onb / 8 < 4) osink[onb / 8] = 1;
                e1++;
                onb++;
            end else if (m_valid_o !== 2'b00) begin
                multi++;
            end
            hs = s_ready_o & s_valid_i;
            prev_rdy = rdy;
            tick();
            if (hs[0]) begin d0 = d0 + 1'b1; sent++; end
            if (hs[1]) begin d1 = d1 + 1'b1; sent++; end
            s_signal_i = {d1, d0};
            if (sent == 32) s_valid_i = 2'b00;
        end
        vectors++; if (nfr !== 4) begin miscompares++; $display("FAIL cont_frames got %0d want 4", nfr); end
        vectors++; if (first_start !== 1) begin miscompares++; $display("FAIL cont_first_grant_cycle got %0d want 1", first_start); end
        vectors++; if (gorder[0] !== 0) begin miscompares++; $display("FAIL cont_grant0 got %0d want 0", gorder[0]); end
        vectors++; if (gorder[1] !== 1) begin miscompares++; $display("FAIL cont_grant1 got %0d want 1", gorder[1]); end
        vectors++; if (gorder[2] !== 0) begin miscompares++; $display("FAIL cont_grant2 got %0d want 0", gorder[2]); end
        vectors++; if (gorder[3] !== 1) begin miscompares++; $display("FAIL cont_grant3 got %0d want 1", gorder[3]); end
        vectors++; if (gap_bad !== 0) begin miscompares++; $display("FAIL cont_gap got %0d bad gaps want 0", gap_bad); end
        vectors++; if (flen_bad !== 0) begin miscompares++; $display("FAIL cont_frame_len got %0d bad frames want 0", flen_bad); end
        vectors++; if (onb !== 32) begin miscompares++; $display("FAIL cont_out_beats got %0d want 32", onb); end
        vectors++; if (osink[0] !== 0) begin miscompares++; $display("FAIL cont_sink0 got %0d want 0", osink[0]); end
        vectors++; if (osink[1] !== 1) begin miscompares++; $display("FAIL cont_sink1 got %0d want 1", osink[1]); end
        vectors++; if (osink[2] !== 0) begin miscompares++; $display("FAIL cont_sink2 got %0d want 0", osink[2]); end
        vectors++; if (osink[3] !== 1) begin miscompares++; $display("FAIL cont_sink3 got %0d want 1", osink[3]); end
        vectors++; if (odbad !== 0) begin miscompares++; $display("FAIL cont_out_data got %0d bad want 0", odbad); end
        vectors++; if (multi !== 0) begin miscompares++; $display("FAIL cont_onehot got %0d bad want 0", multi); end
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL cont_busy_done got %b want 0", busy_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL cont_err got %b want 0", err_o); end
    endtask

    task automatic test_tag_full;
        logic [1:0] hs;
        int sent = 0;
        int stuck = 0;
        int early = 0;
        core_out_en = 1'b1;
        m_ready_i   = 2'b00;
        s_signal_i  = {50'h0, 50'h3000};
        s_valid_i   = 2'b01;
        for (int c = 0; c < 80 && sent < 32; c++) begin
            #1;
            hs = s_ready_o & s_valid_i;
            tick();
            if (hs[0]) sent++;
        end
        vectors++; if (sent !== 32) begin miscompares++; $display("FAIL full_four_frames got %0d beats want 32", sent); end
        for (int c = 0; c < 6; c++) begin
            #1;
            if (s_ready_o !== 2'b00 || core_valid_o !== 1'b0) stuck++;
            tick();
        end
        vectors++; if (stuck !== 0) begin miscompares++; $display("FAIL full_no_grant got %0d bad cycles want 0", stuck); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL full_busy got %b want 1", busy_o); end
        vectors++; if (m_valid_o !== 2'b01) begin miscompares++; $display("FAIL full_m_valid got %b want 01", m_valid_o); end
        vectors++; if (core_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_core_ready got %b want 0", core_ready_o); end
        m_ready_i = 2'b01;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (s_ready_o !== 2'b00) early++;
            tick();
        end
        vectors++; if (early !== 0) begin miscompares++; $display("FAIL full_early_grant got %0d cycles want 0", early); end
        vectors++; if (s_ready_o !== 2'b01) begin miscompares++; $display("FAIL full_fifth_grant got %b want 01", s_ready_o); end
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            #1;
            hs = s_ready_o & s_valid_i;
            tick();
            if (hs[0]) sent++;
            if (sent == 8) s_valid_i = 2'b00;
        end
        s_valid_i = 2'b00;
        m_ready_i = 2'b11;
        for (int c = 0; c < 100 && busy_o; c++) tick();
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL full_drain got busy %b want 0", busy_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL full_err got %b want 0", err_o); end
    endtask

    task automatic test_valid_drop;
        int hold_bad = 0;
        int rest_bad = 0;
        m_ready_i    = 2'b11;
        core_ready_i = 1'b1;
        s_signal_i   = {50'h4100, 50'h4000};
        s_valid_i    = 2'b11;
        #1;
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL drop_arb_cycle got %b want 00", s_ready_o); end
        tick();
        vectors++; if (s_ready_o !== 2'b10) begin miscompares++; $display("FAIL drop_grant1 got %b want 10", s_ready_o); end
        for (int b = 0; b < 3; b++) tick();
        s_valid_i = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_ready_o !== 2'b10 || core_valid_o !== 1'b0) hold_bad++;
            tick();
        end
        vectors++; if (hold_bad !== 0) begin miscompares++; $display("FAIL drop_hold got %0d bad cycles want 0", hold_bad); end
        s_valid_i = 2'b11;
        for (int b = 0; b < 5; b++) begin
            #1;
            if (s_ready_o !== 2'b10 || core_valid_o !== 1'b1) rest_bad++;
            tick();
        end
        vectors++; if (rest_bad !== 0) begin miscompares++; $display("FAIL drop_rest got %0d bad beats want 0", rest_bad); end
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL drop_arb_after got %b want 00", s_ready_o); end
        tick();
        vectors++; if (s_ready_o !== 2'b01) begin miscompares++; $display("FAIL drop_grant0 got %b want 01", s_ready_o); end
        s_valid_i = 2'b01;
        for (int b = 0; b < 8; b++) tick();
        s_valid_i = 2'b00;
        for (int c = 0; c < 100 && busy_o; c++) tick();
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL drop_drain got busy %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] d0;
        logic [1:0] hs;
        int sent = 0;
        int ob = 0;
        int odbad = 0;
        core_out_en  = 1'b1;
        m_ready_i    = 2'b11;
        core_ready_i = 1'b1;
        d0 = 50'h500;
        s_signal_i = {50'h0, d0};
        s_valid_i  = 2'b01;
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            d0 = d0 + 1'b1;
            s_signal_i = {50'h0, d0};
        end
        vectors++; if (m_valid_o !== 2'b01) begin miscompares++; $display("FAIL rmid_pre_m_valid got %b want 01", m_valid_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_busy got %b want 1", busy_o); end
        rst_i = 1'b0;
        #1;
        vectors++; if (s_ready_o !== 2'b00) begin miscompares++; $display("FAIL rmid_s_ready got %b want 00", s_ready_o); end
        vectors++; if (core_valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_core_valid got %b want 0", core_valid_o); end
        vectors++; if (m_valid_o !== 2'b00) begin miscompares++; $display("FAIL rmid_m_valid got %b want 00", m_valid_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy_o); end
        vectors++; if (core_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_core_ready got %b want 1", core_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        d0 = 50'h600;
        s_signal_i = {50'h0, d0};
        tick();
        vectors++; if (s_ready_o !== 2'b01) begin miscompares++; $display("FAIL rmid_regrant got %b want 01", s_ready_o); end
        for (int c = 0; c < 40 && !(sent == 8 && ob == 8); c++) begin
            #1;
            if (m_valid_o === 2'b01) begin
                if (m_signal_o !== ((50'h600 + DW'(ob)) ^ XORC)) odbad++;
                ob++;
            end else if (m_valid_o !== 2'b00) begin
                odbad++;
            end
            hs = s_ready_o & s_valid_i;
            tick();
            if (hs[0]) begin sent++; d0 = d0 + 1'b1; end
            s_signal_i = {50'h0, d0};
            if (sent == 8) s_valid_i = 2'b00;
        end
        s_valid_i = 2'b00;
        vectors++; if (sent !== 8) begin miscompares++; $display("FAIL rmid_in_beats got %0d want 8", sent); end
        vectors++; if (ob !== 8) begin miscompares++; $display("FAIL rmid_out_beats got %0d want 8", ob); end
        vectors++; if (odbad !== 0) begin miscompares++; $display("FAIL rmid_out_data got %0d bad want 0", odbad); end
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmid_busy_done got %b want 0", busy_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL rmid_err got %b want 0", err_o); end
    endtask

    task automatic test_spurious;
        s_valid_i = 2'b00;
        spur = 1'b1;
        #1;
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL spur_err_before got %b want 0", err_o); end
        vectors++; if (m_valid_o !== 2'b00) begin miscompares++; $display("FAIL spur_m_valid got %b want 00", m_valid_o); end
        vectors++; if (core_ready_o !== 1'b1) begin miscompares++; $display("FAIL spur_core_ready got %b want 1", core_ready_o); end
        tick();
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL spur_err_set got %b want 1", err_o); end
        vectors++; if (m_valid_o !== 2'b00) begin miscompares++; $display("FAIL spur_m_valid_after got %b want 00", m_valid_o); end
        spur = 1'b0;
        tick();
        tick();
        vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL spur_err_sticky got %b want 1", err_o); end
        rst_i = 1'b0;
        #1;
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL spur_err_reset got %b want 0", err_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_tag_full();
        test_valid_drop();
        test_reset_mid();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
